// File: rtl/eb1_dec_trig_hit_pipe_pkg.sv
// Shared types for the i0 trigger-hit pipeline (D -> X -> R).
package eb1_dec_trig_hit_pipe_pkg;

    // Trigger count the stage packet is sized for; chain pairs are {0,1}, {2,3}, ...
    localparam int EB1_NUM_TRIG = 4;

    // One stage worth of trigger-hit state, used for both the X and R registers.
    typedef struct packed {
        logic                    valid;
        logic [EB1_NUM_TRIG-1:0] hit;
        logic                    halt;
        logic                    exc;
    } eb1_trig_hit_pkt_t;

    localparam eb1_trig_hit_pkt_t EB1_TRIG_PKT_IDLE = '0;

endpackage

// File: rtl/eb1_dec_trig_hit_pipe_if.sv
// Decode-side inputs and R-stage trigger outputs of the hit pipeline.
interface eb1_dec_trig_hit_pipe_if
    import eb1_dec_trig_hit_pipe_pkg::*;
#(
    parameter int NUM_TRIG = EB1_NUM_TRIG
);
    logic [NUM_TRIG-1:0] dec_i0_trigger_match_d;
    logic                dec_i0_valid_d;
    logic                dec_d_adv;
    logic                dec_x_adv;
    logic                dec_tlu_flush_lower_r;
    logic [NUM_TRIG-1:0] mtdata1_chain;
    logic [NUM_TRIG-1:0] mtdata1_action;
    logic                dec_tlu_dbg_mode;

    logic                dec_i0_trigger_valid_r;
    logic [NUM_TRIG-1:0] dec_i0_trigger_hit_r;
    logic                dec_i0_trigger_halt_r;
    logic                dec_i0_trigger_exc_r;

    // Decode/TLU side: drives match, pipeline control and trigger config.
    modport master (
        output dec_i0_trigger_match_d, dec_i0_valid_d, dec_d_adv, dec_x_adv,
               dec_tlu_flush_lower_r, mtdata1_chain, mtdata1_action, dec_tlu_dbg_mode,
        input  dec_i0_trigger_valid_r, dec_i0_trigger_hit_r,
               dec_i0_trigger_halt_r, dec_i0_trigger_exc_r
    );

    // Hit pipeline side.
    modport slave (
        input  dec_i0_trigger_match_d, dec_i0_valid_d, dec_d_adv, dec_x_adv,
               dec_tlu_flush_lower_r, mtdata1_chain, mtdata1_action, dec_tlu_dbg_mode,
        output dec_i0_trigger_valid_r, dec_i0_trigger_hit_r,
               dec_i0_trigger_halt_r, dec_i0_trigger_exc_r
    );

endinterface

// File: rtl/eb1_dec_trig_hit_pipe_chain_resolve.sv
// Combinational D-stage trigger resolution: qualify raw matches, apply pair
// chaining, and reduce the per-trigger action to one halt/exception decision.
module eb1_trig_chain_resolve
    import eb1_dec_trig_hit_pipe_pkg::*;
#(
    parameter int NUM_TRIG = EB1_NUM_TRIG
) (
    input  logic [NUM_TRIG-1:0] match,
    input  logic                valid_d,
    input  logic                dbg_mode,
    input  logic [NUM_TRIG-1:0] chain,
    input  logic [NUM_TRIG-1:0] action,
    output eb1_trig_hit_pkt_t   pkt_d
);

    logic [NUM_TRIG-1:0] q;
    logic [NUM_TRIG-1:0] hit;
    logic [NUM_TRIG-1:0] act_eff;

    // Debug mode and an invalid slot both mask every new match.
    assign q = match & {NUM_TRIG{valid_d & ~dbg_mode}};

    for (genvar k = 0; k < NUM_TRIG; k += 2) begin : g_pair
        logic pair_hit;
        logic unused_chain_odd;

        // Odd chain bits carry no meaning; the even bit owns the pair.
        assign unused_chain_odd = chain[k+1];
        assign pair_hit         = q[k] & q[k+1];

        // A chained pair fires only as a whole and takes the even trigger's action.
        assign hit[k]       = chain[k] ? pair_hit  : q[k];
        assign hit[k+1]     = chain[k] ? pair_hit  : q[k+1];
        assign act_eff[k]   = action[k];
        assign act_eff[k+1] = chain[k] ? action[k] : action[k+1];
    end

    // Halt wins over exception whenever any hit trigger asks for it.
    always_comb begin
        pkt_d       = EB1_TRIG_PKT_IDLE;
        pkt_d.hit   = hit;
        pkt_d.valid = |hit;
        pkt_d.halt  = |(hit & act_eff);
        pkt_d.exc   = (|hit) & ~pkt_d.halt;
    end

endmodule

// File: rtl/eb1_dec_trig_hit_pipe.sv
// i0 trigger-hit pipeline: resolves hits at D, carries them through X and
// presents a one-cycle, flush-qualified pulse at R. NUM_TRIG must be even and
// equal to EB1_NUM_TRIG, which sizes the stage packet.
module eb1_dec_trig_hit_pipe
    import eb1_dec_trig_hit_pipe_pkg::*;
#(
    parameter int NUM_TRIG = EB1_NUM_TRIG
) (
    input logic                     clk,
    input logic                     rst_l,
    eb1_dec_trig_hit_pipe_if.slave  tif
);

    eb1_trig_hit_pkt_t pkt_d;
    eb1_trig_hit_pkt_t x_d, x_q;
    eb1_trig_hit_pkt_t r_d, r_q;

    eb1_trig_chain_resolve #(.NUM_TRIG(NUM_TRIG)) u_resolve (
        .match    (tif.dec_i0_trigger_match_d),
        .valid_d  (tif.dec_i0_valid_d),
        .dbg_mode (tif.dec_tlu_dbg_mode),
        .chain    (tif.mtdata1_chain),
        .action   (tif.mtdata1_action),
        .pkt_d    (pkt_d)
    );

    // X stage: flush clears, D advance loads, X draining without a refill leaves a bubble.
    always_comb begin
        x_d = x_q;
        if (tif.dec_tlu_flush_lower_r) begin
            x_d = EB1_TRIG_PKT_IDLE;
        end else if (tif.dec_d_adv) begin
            x_d = pkt_d;
        end else if (tif.dec_x_adv) begin
            x_d = EB1_TRIG_PKT_IDLE;
        end
    end

    // R stage: a single-cycle pulse per retirement, so a stalled hit never repeats.
    always_comb begin
        r_d = EB1_TRIG_PKT_IDLE;
        if (tif.dec_x_adv && !tif.dec_tlu_flush_lower_r) begin
            r_d = x_q;
        end
    end

    // Stage registers, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            x_q <= EB1_TRIG_PKT_IDLE;
            r_q <= EB1_TRIG_PKT_IDLE;
        end else begin
            x_q <= x_d;
            r_q <= r_d;
        end
    end

    // Outputs come straight off the R flops.
    assign tif.dec_i0_trigger_valid_r = r_q.valid;
    assign tif.dec_i0_trigger_hit_r   = r_q.hit;
    assign tif.dec_i0_trigger_halt_r  = r_q.halt;
    assign tif.dec_i0_trigger_exc_r   = r_q.exc;

endmodule
